// File: rtl/mlaccel_pkg.sv
// mlaccel_pkg
//   Shared widths, port identifiers and the read-tag type used by the
//   memory arbiter and its read-tag pipeline.
package mlaccel_pkg;

    localparam int MEM_AW = 16;   // word address width
    localparam int MEM_WW = 16;   // write data width
    localparam int MEM_RW = 64;   // read data width

    localparam logic PORT_H = 1'b0;
    localparam logic PORT_C = 1'b1;

    // Tag carried alongside an outstanding read until its data returns.
    typedef struct packed {
        logic valid;
        logic port;
    } rtag_t;

endpackage

// File: rtl/mlaccel_rtag_pipe.sv
// mlaccel_rtag_pipe
//   Fixed-depth shift register of read tags. A tag entering at a grant
//   leaves exactly DEPTH cycles later, lined up with the memory read data.
// Ports
//   clock   in   1    clock, posedge
//   resetn  in   1    async active-low reset, clears every stage
//   i_tag   in   2    tag entering at grant
//   o_tag   out  2    tag whose read data is on mem_rdata this cycle
module mlaccel_rtag_pipe
    import mlaccel_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic  clock,
    input  logic  resetn,
    input  rtag_t i_tag,
    output rtag_t o_tag
);

    rtag_t r_stage [DEPTH];

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_stage[i] <= '0;
            end
        end else begin
            r_stage[0] <= i_tag;
            for (int i = 1; i < DEPTH; i++) begin
                r_stage[i] <= r_stage[i-1];
            end
        end
    end

    assign o_tag = r_stage[DEPTH-1];

endmodule

// File: rtl/mlaccel_mem_arbiter.sv
// mlaccel_mem_arbiter
//   Shares the single-port accelerator memory between the host command
//   engine (H) and the compute sequencer (C). One grant per cycle, compute
//   bursts bounded so the host waits at most MAX_BURST cycles, idle memory
//   inputs driven to zero, read data routed back to the issuing port.
// Ports
//   clock, resetn                 clock / async active-low reset
//   h_valid/h_ready               host request handshake (ready is comb.)
//   h_write[1:0], h_addr, h_wdata host byte enables (0 = read), address, data
//   h_rvalid, h_rdata[63:0]       host read return
//   c_*                           same set for the compute sequencer
//   host_excl                     blocks the C port while asserted
//   mem_addr, mem_wen, mem_wdata  to memory (zero when no transfer)
//   mem_rdata                     from memory, READ_LATENCY after address
module mlaccel_mem_arbiter
    import mlaccel_pkg::*;
#(
    parameter int MAX_BURST    = 8,
    parameter int READ_LATENCY = 2
) (
    input  logic              clock,
    input  logic              resetn,
    input  logic              h_valid,
    output logic              h_ready,
    input  logic [1:0]        h_write,
    input  logic [MEM_AW-1:0] h_addr,
    input  logic [MEM_WW-1:0] h_wdata,
    output logic              h_rvalid,
    output logic [MEM_RW-1:0] h_rdata,
    input  logic              c_valid,
    output logic              c_ready,
    input  logic [1:0]        c_write,
    input  logic [MEM_AW-1:0] c_addr,
    input  logic [MEM_WW-1:0] c_wdata,
    output logic              c_rvalid,
    output logic [MEM_RW-1:0] c_rdata,
    input  logic              host_excl,
    output logic [MEM_AW-1:0] mem_addr,
    output logic [1:0]        mem_wen,
    output logic [MEM_WW-1:0] mem_wdata,
    input  logic [MEM_RW-1:0] mem_rdata
);

    logic [7:0]        r_burst_cnt;
    logic [MEM_RW-1:0] r_h_rdata;
    logic [MEM_RW-1:0] r_c_rdata;

    logic  w_h_elig;
    logic  w_c_elig;
    logic  w_burst_ok;
    logic  w_h_gnt;
    logic  w_c_gnt;
    rtag_t w_tag_in;
    rtag_t w_tag_out;

    // Gating with resetn keeps both readies low while reset is held.
    assign w_h_elig   = h_valid & resetn;
    assign w_c_elig   = c_valid & ~host_excl & resetn;
    assign w_burst_ok = r_burst_cnt < 8'(MAX_BURST);
    assign w_c_gnt    = w_c_elig & (~w_h_elig | w_burst_ok);
    assign w_h_gnt    = w_h_elig & ~w_c_gnt;

    assign h_ready = w_h_gnt;
    assign c_ready = w_c_gnt;

    always_comb begin
        mem_addr  = '0;
        mem_wen   = '0;
        mem_wdata = '0;
        if (w_c_gnt) begin
            mem_addr  = c_addr;
            mem_wen   = c_write;
            mem_wdata = c_wdata;
        end else if (w_h_gnt) begin
            mem_addr  = h_addr;
            mem_wen   = h_write;
            mem_wdata = h_wdata;
        end
    end

    // Counts C grants that overtook a waiting host; any cycle without a
    // waiting host, or a host grant, starts the window over.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_burst_cnt <= '0;
        end else if (!h_valid || w_h_gnt) begin
            r_burst_cnt <= '0;
        end else if (w_c_gnt && r_burst_cnt != 8'hFF) begin
            r_burst_cnt <= r_burst_cnt + 8'd1;
        end
    end

    assign w_tag_in.valid = (w_c_gnt && c_write == 2'b00) || (w_h_gnt && h_write == 2'b00);
    assign w_tag_in.port  = w_c_gnt ? PORT_C : PORT_H;

    mlaccel_rtag_pipe #(
        .DEPTH (READ_LATENCY)
    ) u_rtag_pipe (
        .clock  (clock),
        .resetn (resetn),
        .i_tag  (w_tag_in),
        .o_tag  (w_tag_out)
    );

    assign h_rvalid = w_tag_out.valid && w_tag_out.port == PORT_H;
    assign c_rvalid = w_tag_out.valid && w_tag_out.port == PORT_C;

    // Returning data passes straight through; the non-owner keeps its last word.
    assign h_rdata = h_rvalid ? mem_rdata : r_h_rdata;
    assign c_rdata = c_rvalid ? mem_rdata : r_c_rdata;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_h_rdata <= '0;
            r_c_rdata <= '0;
        end else begin
            if (h_rvalid) r_h_rdata <= mem_rdata;
            if (c_rvalid) r_c_rdata <= mem_rdata;
        end
    end

endmodule

// File: tb/tb_mlaccel_mem_arbiter.sv
module tb_mlaccel_mem_arbiter;
    import mlaccel_pkg::*;

    localparam int MAXB = 8;
    localparam int RL   = 2;

    logic        clock = 1'b0;
    logic        resetn;
    logic        h_valid, h_ready, h_rvalid;
    logic [1:0]  h_write;
    logic [15:0] h_addr, h_wdata;
    logic [63:0] h_rdata;
    logic        c_valid, c_ready, c_rvalid;
    logic [1:0]  c_write;
    logic [15:0] c_addr, c_wdata;
    logic [63:0] c_rdata;
    logic        host_excl;
    logic [15:0] mem_addr, mem_wdata;
    logic [1:0]  mem_wen;
    logic [63:0] mem_rdata;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int bcnt;

    typedef struct {
        logic        port;
        logic [63:0] data;
        int          due;
    } sb_t;
    sb_t sbq[$];
    logic [63:0] last_h = '0;
    logic [63:0] last_c = '0;

    always #5 clock = ~clock;

    mlaccel_mem_arbiter #(.MAX_BURST(MAXB), .READ_LATENCY(RL)) dut (
        .clock(clock), .resetn(resetn),
        .h_valid(h_valid), .h_ready(h_ready), .h_write(h_write), .h_addr(h_addr),
        .h_wdata(h_wdata), .h_rvalid(h_rvalid), .h_rdata(h_rdata),
        .c_valid(c_valid), .c_ready(c_ready), .c_write(c_write), .c_addr(c_addr),
        .c_wdata(c_wdata), .c_rvalid(c_rvalid), .c_rdata(c_rdata),
        .host_excl(host_excl),
        .mem_addr(mem_addr), .mem_wen(mem_wen), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    function automatic logic [63:0] memfunc(logic [15:0] a);
        if (a == 16'h0010) return 64'h1122334455667788;
        return {a, a ^ 16'hFFFF, a ^ 16'h1234, a + 16'h0101};
    endfunction

    // Memory model: read data appears RL (=2) cycles after the address.
    logic [63:0] rd1 = '0;
    logic [63:0] rd2 = '0;
    always @(posedge clock) begin
        rd1 <= memfunc(mem_addr);
        rd2 <= rd1;
    end
    assign mem_rdata = rd2;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Scoreboard: pushes on every observed read transfer, checks returns.
    always @(negedge clock) begin
        if (!resetn) begin
            sbq.delete();
            last_h = '0;
            last_c = '0;
            chk("rst_h_rvalid", h_rvalid, 0);
            chk("rst_c_rvalid", c_rvalid, 0);
        end else begin
            if (sbq.size() > 0 && sbq[0].due == cyc) begin
                sb_t e;
                e = sbq.pop_front();
                if (e.port == PORT_H) begin
                    chk("ret_h_rvalid", h_rvalid, 1);
                    chk("ret_h_rdata", h_rdata, e.data);
                    chk("ret_c_quiet", c_rvalid, 0);
                    chk("hold_c_rdata", c_rdata, last_c);
                    last_h = e.data;
                end else begin
                    chk("ret_c_rvalid", c_rvalid, 1);
                    chk("ret_c_rdata", c_rdata, e.data);
                    chk("ret_h_quiet", h_rvalid, 0);
                    chk("hold_h_rdata", h_rdata, last_h);
                    last_c = e.data;
                end
            end else begin
                chk("idle_h_rvalid", h_rvalid, 0);
                chk("idle_c_rvalid", c_rvalid, 0);
            end
            if (h_valid && h_ready && h_write == 2'b00)
                sbq.push_back('{port: PORT_H, data: memfunc(h_addr), due: cyc + RL});
            if (c_valid && c_ready && c_write == 2'b00)
                sbq.push_back('{port: PORT_C, data: memfunc(c_addr), due: cyc + RL});
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic samp();
        @(negedge clock);
    endtask

    initial begin
        resetn = 1'b0; host_excl = 1'b0;
        h_valid = 1'b1; h_write = '0; h_addr = 16'h0001; h_wdata = '0;
        c_valid = 1'b1; c_write = '0; c_addr = 16'h0002; c_wdata = '0;

        // Reset: readies and memory bus held at zero even with requests up.
        samp();
        chk("rst_h_ready", h_ready, 0);
        chk("rst_c_ready", c_ready, 0);
        chk("rst_mem_addr", mem_addr, 0);
        tick();
        h_valid = 1'b0; c_valid = 1'b0;
        tick();
        resetn = 1'b1;

        // 1: single host read of 0x0010
        h_valid = 1'b1; h_addr = 16'h0010;
        samp();
        chk("t1_h_ready", h_ready, 1);
        chk("t1_c_ready", c_ready, 0);
        chk("t1_mem_addr", mem_addr, 16'h0010);
        chk("t1_mem_wen", mem_wen, 0);
        tick();
        h_valid = 1'b0;
        samp();
        chk("t1_idle_addr", mem_addr, 0);
        repeat (3) tick();

        // 2: both valid continuously, burst limit
        bcnt = 0;
        h_valid = 1'b1; h_addr = 16'h0100;
        c_valid = 1'b1; c_addr = 16'h0300;
        for (int i = 0; i < 2 * (MAXB + 1); i++) begin
            logic cwin;
            cwin = (bcnt < MAXB);
            samp();
            chk("t2_c_ready", c_ready, cwin);
            chk("t2_h_ready", h_ready, !cwin);
            chk("t2_mem_addr", mem_addr, cwin ? 16'h0300 : 16'h0100);
            bcnt = cwin ? bcnt + 1 : 0;
            tick();
        end
        h_valid = 1'b0; c_valid = 1'b0;
        samp();
        chk("t2_idle_addr", mem_addr, 0);
        chk("t2_idle_wen", mem_wen, 0);
        chk("t2_idle_wdata", mem_wdata, 0);
        repeat (3) tick();

        // 3: C write blocked by host_excl, issued once it drops
        host_excl = 1'b1;
        c_valid = 1'b1; c_write = 2'b11; c_addr = 16'h0200; c_wdata = 16'h00A5;
        repeat (4) begin
            samp();
            chk("t3_excl_c_ready", c_ready, 0);
            chk("t3_excl_mem_wen", mem_wen, 0);
            tick();
        end
        host_excl = 1'b0;
        samp();
        chk("t3_c_ready", c_ready, 1);
        chk("t3_mem_addr", mem_addr, 16'h0200);
        chk("t3_mem_wen", mem_wen, 2'b11);
        chk("t3_mem_wdata", mem_wdata, 16'h00A5);
        tick();
        c_valid = 1'b0; c_write = 2'b00;
        repeat (4) tick();

        // 4: alternating H/C reads every cycle
        for (int i = 0; i < 6; i++) begin
            h_valid = (i % 2 == 0);
            c_valid = (i % 2 == 1);
            h_addr  = 16'h0400 + 16'(i);
            c_addr  = 16'h0500 + 16'(i);
            samp();
            chk("t4_h_ready", h_ready, (i % 2 == 0));
            chk("t4_c_ready", c_ready, (i % 2 == 1));
            tick();
        end
        h_valid = 1'b0; c_valid = 1'b0;
        repeat (2) tick();

        // 4b: host_excl rises while a C read is in flight
        c_valid = 1'b1; c_addr = 16'h0700;
        samp();
        chk("t4b_c_ready", c_ready, 1);
        tick();
        c_valid = 1'b0; host_excl = 1'b1;
        repeat (3) tick();
        host_excl = 1'b0;

        // 5: fill the burst window, reset with reads in flight
        h_valid = 1'b1; h_addr = 16'h0800;
        c_valid = 1'b1; c_addr = 16'h0900;
        repeat (MAXB) begin
            samp();
            chk("t5_c_burst", c_ready, 1);
            tick();
        end
        resetn = 1'b0;
        samp();
        chk("t5_rst_h_ready", h_ready, 0);
        chk("t5_rst_c_ready", c_ready, 0);
        chk("t5_rst_mem_addr", mem_addr, 0);
        tick();
        resetn = 1'b1;
        samp();
        chk("t5_c_first", c_ready, 1);
        chk("t5_h_wait", h_ready, 0);
        chk("t5_mem_addr", mem_addr, 16'h0900);
        tick();
        h_valid = 1'b0; c_valid = 1'b0;
        repeat (4) tick();

        samp();
        chk("sb_drained", 64'(sbq.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
